pack_serializer: RTL
====================

PACK_SERIALIZER -- requirements
Module: pack_serializer

Interface
REQ-001 Parameter N, default 10, number of bytes per input word (N >= 2).
REQ-002 aclk  input  1  single clock; one clock; reset is asynchronous and active-high.
REQ-003 areset  input  1  asynchronous, active-high reset.
REQ-004 in_tdata  input  8*N  densely packed word from the upstream packing stage; byte N-1 (bits 8N-1:8N-8) is the oldest byte.
REQ-005 in_tvalid  input  1  in_tdata valid.
REQ-006 in_tready  output  1  block can accept a word this cycle.
REQ-007 out_tdata  output  8  serialized byte.
REQ-008 out_tvalid  output  1  out_tdata valid.
REQ-009 out_tready  input  1  downstream accepts byte.
REQ-010 out_tlast  output  1  marks the final byte emitted for the current word.
REQ-011 out_tuser  output  1  marks a checksum byte; 0 when PACK_SER_CSUM_EN is undefined.

Function
REQ-012 Input transfer occurs on a rising aclk edge with in_tvalid && in_tready; output transfer occurs on a rising edge with out_tvalid && out_tready.
REQ-013 The FSM SHALL have states IDLE (no word held), SHIFT (emitting data bytes) and CSUM (emitting checksum byte, present only with PACK_SER_CSUM_EN).
REQ-014 IDLE -> SHIFT on input transfer: word latched into holding register, byte index cleared to 0.
REQ-015 In SHIFT, out_tdata SHALL be byte N-1-index of the held word (oldest first); index increments by 1 per output transfer.
REQ-016 Output SHALL be registered: first byte valid on the cycle after the input transfer; one byte per cycle while out_tready=1.
REQ-017 out_tdata, out_tlast, out_tuser SHALL hold stable while out_tvalid=1 and out_tready=0.
REQ-018 Final-byte transfer (index N-1 without CSUM, CSUM byte with it) SHALL return to IDLE, or remain in SHIFT with a new word and index 0 if an input transfer occurs in the same cycle.
REQ-019 in_tready SHALL be 1 in IDLE, and 1 in the cycle the final byte is transferred; 0 otherwise (zero-bubble back-to-back words).
REQ-020 Index counter width SHALL be $clog2(N) bits; it SHALL never exceed N-1.
REQ-021 A word accepted with out_tready held low SHALL be retained indefinitely; no byte dropped or duplicated.

Reset
REQ-022 On areset=1, asynchronously: state=IDLE, index=0, holding register=0, checksum=0, out_tvalid=0, out_tdata=0, out_tlast=0, out_tuser=0.
REQ-023 in_tready SHALL be 0 while areset=1 and 1 from the first edge after deassertion.
REQ-024 Reset mid-word SHALL discard remaining bytes; no partial word emitted afterwards.

Configuration
REQ-025 Macro PACK_SER_CSUM_EN: when defined, after byte index N-1 the block SHALL emit one extra byte = XOR of all N data bytes of the word, with out_tuser=1 and out_tlast=1; data bytes carry out_tuser=0, out_tlast=0.
REQ-026 Without PACK_SER_CSUM_EN: no CSUM state, no checksum logic; out_tlast=1 on byte index N-1; out_tuser tied 0; word period N cycles.
REQ-027 With PACK_SER_CSUM_EN the word period SHALL be N+1 cycles at full throughput.

Verification
REQ-028 N=4, no CSUM, word 0x41424344, out_tready=1 -> bytes 41,42,43,44 on 4 consecutive cycles, out_tlast only on 44.
REQ-029 N=4, no CSUM, two words back-to-back with in_tvalid held -> 8 bytes on 8 consecutive cycles, in_tready pulses with each final byte, no bubble.
REQ-030 N=4, out_tready low for 5 cycles after byte 42 -> 42 held stable, then 43,44 emitted; in_tready=0 throughout stall.
REQ-031 N=4, CSUM_EN, word 0x01020408 -> bytes 01,02,04,08 then 0F with out_tuser=1, out_tlast=1.
REQ-032 areset pulsed after byte 42 of 0x41424344 -> out_tvalid=0 immediately; next word 0x51525354 emitted from 51, no 43/44.
REQ-033 N=10 default, random in_tvalid/out_tready -> byte stream equals concatenation of accepted words MSB-byte first, scoreboard-checked over 1000 words.

Source files
------------

// File: rtl/pack_serializer.sv
// Byte serializer: unpacks an N-byte word oldest byte first onto a byte stream.
// Optional trailing XOR checksum byte is enabled by defining PACK_SER_CSUM_EN.
module pack_serializer #(
    parameter int N = 10
) (
    input  logic           aclk,
    input  logic           areset,
    input  logic [8*N-1:0] in_tdata,
    input  logic           in_tvalid,
    output logic           in_tready,
    output logic [7:0]     out_tdata,
    output logic           out_tvalid,
    input  logic           out_tready,
    output logic           out_tlast,
    output logic           out_tuser
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

`ifdef PACK_SER_CSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, CSUM = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    function automatic logic [7:0] byte_sel(input logic [8*N-1:0] w, input logic [IW-1:0] i);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < N; k++) begin
            if (i == IW'(k)) begin
                r = w[8*(N-1-k) +: 8];
            end
        end
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [8*N-1:0]  hold_q, hold_d;
    logic [IW-1:0]   idx_q, idx_d, idx_nx_s;
    logic [7:0]      dat_q, dat_d;
    logic            vld_q, vld_d;
    logic            last_q, last_d;
    logic            rdy_q;
    logic            in_tready_s, in_xfer_s, out_xfer_s;
`ifdef PACK_SER_CSUM_EN
    logic [7:0]      csum_q, csum_d;
    logic            user_q, user_d;

    function automatic logic [7:0] xor_bytes(input logic [8*N-1:0] w);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < N; k++) begin
            r = r ^ w[8*k +: 8];
        end
        return r;
    endfunction
`endif

    assign idx_nx_s = idx_q + IW'(1);

    // Handshake decode and next-state / next-output computation
    always_comb begin
        in_tready_s = rdy_q && ((state_q == IDLE) || (vld_q && out_tready && last_q));
        in_xfer_s   = in_tvalid && in_tready_s;
        out_xfer_s  = vld_q && out_tready;
        state_d     = state_q;
        hold_d      = hold_q;
        idx_d       = idx_q;
        dat_d       = dat_q;
        vld_d       = vld_q;
        last_d      = last_q;
`ifdef PACK_SER_CSUM_EN
        csum_d      = csum_q;
        user_d      = user_q;
`endif
        if (in_xfer_s) begin
            // New word overrides everything, including a final-byte transfer this cycle.
            state_d = SHIFT;
            hold_d  = in_tdata;
            idx_d   = '0;
            dat_d   = in_tdata[8*N-1 -: 8];
            vld_d   = 1'b1;
            last_d  = 1'b0;
`ifdef PACK_SER_CSUM_EN
            csum_d  = xor_bytes(in_tdata);
            user_d  = 1'b0;
`endif
        end else if (out_xfer_s) begin
            case (state_q)
                SHIFT: begin
                    if (idx_q == LAST_IDX) begin
`ifdef PACK_SER_CSUM_EN
                        state_d = CSUM;
                        dat_d   = csum_q;
                        last_d  = 1'b1;
                        user_d  = 1'b1;
`else
                        state_d = IDLE;
                        idx_d   = '0;
                        dat_d   = 8'h00;
                        vld_d   = 1'b0;
                        last_d  = 1'b0;
`endif
                    end else begin
                        idx_d  = idx_nx_s;
                        dat_d  = byte_sel(hold_q, idx_nx_s);
`ifdef PACK_SER_CSUM_EN
                        last_d = 1'b0;
`else
                        last_d = (idx_nx_s == LAST_IDX);
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                    dat_d   = 8'h00;
                    vld_d   = 1'b0;
                    last_d  = 1'b0;
`ifdef PACK_SER_CSUM_EN
                    user_d  = 1'b0;
`endif
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and registered output stage
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
            dat_q   <= 8'h00;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef PACK_SER_CSUM_EN
            csum_q  <= 8'h00;
            user_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            dat_q   <= dat_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            rdy_q   <= 1'b1;
`ifdef PACK_SER_CSUM_EN
            csum_q  <= csum_d;
            user_q  <= user_d;
`endif
        end
    end

    assign in_tready  = in_tready_s;
    assign out_tdata  = dat_q;
    assign out_tvalid = vld_q;
    assign out_tlast  = last_q;
`ifdef PACK_SER_CSUM_EN
    assign out_tuser  = user_q;
`else
    assign out_tuser  = 1'b0;
`endif

endmodule
